// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, line levels and a frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Cycles on the line for one frame, excluding the IDLE/FETCH/WAIT overhead.
    function automatic int frame_cycles(input int clks_per_bit, input int data_w, input bit parity);
        return (data_w + 32'sd2 + (parity ? 32'sd1 : 32'sd0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_tick on wrap.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 32'sd1);

    logic [CNT_W-1:0] cnt_r;

    assign bit_tick = en && !clr && (cnt_r == CNT_MAX);

    // Baud counter with synchronous clear taking priority over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_MAX) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining an 8-bit synchronous FIFO as 8N1 frames on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 32'sd1);

    uart_state_t       state_r;
    uart_state_t       state_s;
    logic [DATA_W-1:0] shift_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic              baud_en_s;
    logic              bit_tick_s;
    logic              last_bit_s;
    logic              tx_s;

`ifdef UART_TX_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    assign baud_en_s  = (state_r != IDLE) && (state_r != FETCH) && (state_r != WAIT);
    assign last_bit_s = (bit_idx_r == LAST_IDX);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (baud_en_s),
        .clr     (~baud_en_s),
        .bit_tick(bit_tick_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; fifo_empty is only looked at in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) state_s = FETCH;
                else             state_s = IDLE;
            end
            FETCH: state_s = WAIT;
            WAIT:  state_s = START;
            START: begin
                if (bit_tick_s) state_s = DATA;
                else            state_s = START;
            end
            DATA: begin
                if (bit_tick_s && last_bit_s) begin
`ifdef UART_TX_PARITY_EN
                    state_s = PARITY;
`else
                    state_s = STOP;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick_s) state_s = STOP;
                else            state_s = PARITY;
            end
`endif
            STOP: begin
                if (bit_tick_s) state_s = IDLE;
                else            state_s = STOP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Line level for the current state, registered below.
    always_comb begin
        tx_s = STOP_BIT;
        case (state_r)
            START:   tx_s = START_BIT;
            DATA:    tx_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = parity_r;
`endif
            default: tx_s = STOP_BIT;
        endcase
    end

    // Datapath and registered outputs; fifo_data is valid in WAIT, one cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r    <= '0;
            bit_idx_r  <= '0;
            fifo_rd_en <= 1'b0;
            tx         <= STOP_BIT;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            fifo_rd_en <= (state_s == FETCH);
            busy       <= (state_s != IDLE);
            tx         <= tx_s;
            byte_done  <= (state_r == STOP) && bit_tick_s;
            if (state_r == WAIT) begin
                shift_r <= fifo_data;
            end else if ((state_r == DATA) && bit_tick_s) begin
                shift_r <= {1'b0, shift_r[DATA_W-1:1]};
            end else begin
                shift_r <= shift_r;
            end
            if ((state_r == DATA) && bit_tick_s) begin
                bit_idx_r <= last_bit_s ? '0 : bit_idx_r + IDX_W'(1'b1);
            end else begin
                bit_idx_r <= bit_idx_r;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as captured, before any shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_r <= 1'b0;
        end else if (state_r == WAIT) begin
            parity_r <= even_parity(fifo_data);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a CLKS_PER_BIT=4 instance fed by a small FIFO model
// with a one-cycle-late empty flag, plus a CLKS_PER_BIT=16 instance for baud scaling.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME4 = NB * CPB;

    typedef struct {
        logic [7:0] data;
        logic [9:0] exp_frame;  // line levels in send order, bit 0 first: start, d0..d7, stop
        logic       exp_par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       empty_r = 1'b1;
    logic [7:0] fifo_q_data = 8'h00;
    logic [7:0] q[$];
    logic       u4_rd_en, u4_tx, u4_busy, u4_done;
    int         underflow_cnt = 0;
    int         overflow_cnt = 0;
    int         rd_cnt = 0;
    int         cyc = 0;

    logic       u16_pending = 1'b0;
    logic       u16_taken = 1'b0;
    logic [7:0] u16_data = 8'h00;
    logic       u16_empty;
    logic       u16_rd_en, u16_tx, u16_busy, u16_done;
    int         rd16_cnt = 0;

    int tests = 0;
    int fails = 0;

    vec_t vecs [6];
    vec_t bb [4];
    vec_t lag [2];

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) u4 (
        .clk(clk), .rst(rst), .fifo_empty(empty_r), .fifo_data(fifo_q_data),
        .fifo_rd_en(u4_rd_en), .tx(u4_tx), .busy(u4_busy), .byte_done(u4_done)
    );

    assign u16_empty = !u16_pending || u16_taken;

    fifo_uart_tx #(.CLKS_PER_BIT(16), .DATA_W(8)) u16 (
        .clk(clk), .rst(rst), .fifo_empty(u16_empty), .fifo_data(u16_data),
        .fifo_rd_en(u16_rd_en), .tx(u16_tx), .busy(u16_busy), .byte_done(u16_done)
    );

    // FIFO model, depth 4; empty reflects the occupancy before this edge (one cycle late).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        empty_r <= (q.size() == 0);
        if (u4_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (q.size() == 0) underflow_cnt <= underflow_cnt + 1;
            else fifo_q_data <= q.pop_front();
        end
        if (wr_en) begin
            if (q.size() >= 4) overflow_cnt <= overflow_cnt + 1;
            else q.push_back(wr_data);
        end
    end

    // Single-byte source for the 16x instance.
    always @(posedge clk) begin
        if (u16_rd_en) begin
            rd16_cnt  <= rd16_cnt + 1;
            u16_data  <= 8'hFF;
            u16_taken <= 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic push_end();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_tx_low(input bit use16, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if ((use16 ? u16_tx : u4_tx) == 1'b0) ok = 1'b1;
        end
    endtask

    function automatic logic frame_bit(input vec_t v, input int b);
`ifdef UART_TX_PARITY_EN
        if (b < 9)       return v.exp_frame[b];
        else if (b == 9) return v.exp_par;
        else             return v.exp_frame[9];
`else
        return v.exp_frame[b];
`endif
    endfunction

    // Waits for a start bit, then checks every cycle of the frame and the byte_done position.
    task automatic check_frame(input vec_t v, output int fall_cyc);
        bit ok;
        int bit_err [NB];
        int done_err;
        wait_tx_low(1'b0, ok);
        check($sformatf("frame_%02h_start_seen", v.data), ok, 1);
        fall_cyc = cyc;
        if (ok) begin
            check($sformatf("frame_%02h_busy", v.data), u4_busy, 1);
            done_err = 0;
            for (int b = 0; b < NB; b++) bit_err[b] = 0;
            for (int j = 0; j < FRAME4; j++) begin
                if (j > 0) @(negedge clk);
                if (u4_tx !== frame_bit(v, j / CPB)) bit_err[j / CPB]++;
                if (u4_done !== 1'(j == FRAME4 - 1)) done_err++;
            end
            for (int b = 0; b < NB; b++)
                check($sformatf("frame_%02h_bit%0d", v.data, b), bit_err[b], 0);
            check($sformatf("frame_%02h_byte_done", v.data), done_err, 0);
        end
    endtask

    initial begin
        int  f [4];
        int  r0, dummy, lowcnt, start_err, body_err, done_pos, done_cnt;
        bit  ok;
        logic e;

        vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
        vecs[1] = '{8'h07, 10'b1000001110, 1'b1};
        vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
        vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};
        vecs[4] = '{8'h3C, 10'b1001111000, 1'b0};
        vecs[5] = '{8'h80, 10'b1100000000, 1'b1};
        bb[0]   = '{8'h01, 10'b1000000010, 1'b1};
        bb[1]   = '{8'h02, 10'b1000000100, 1'b1};
        bb[2]   = '{8'h03, 10'b1000000110, 1'b0};
        bb[3]   = '{8'h04, 10'b1000001000, 1'b1};
        lag[0]  = '{8'h5A, 10'b1010110100, 1'b0};
        lag[1]  = '{8'hC3, 10'b1110000110, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", u4_tx, 1);
        check("rst_busy", u4_busy, 0);
        check("rst_rd_en", u4_rd_en, 0);
        check("rst_byte_done", u4_done, 0);
        check("rst_tx16", u16_tx, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_read", rd_cnt, 0);

        // Single frames from the vector table.
        for (int i = 0; i < 6; i++) begin
            r0 = rd_cnt;
            push(vecs[i].data);
            push_end();
            check_frame(vecs[i], dummy);
            repeat (6) @(negedge clk);
            check($sformatf("single_read_%02h", vecs[i].data), rd_cnt, r0 + 1);
            check($sformatf("idle_busy_%02h", vecs[i].data), u4_busy, 0);
        end

        // Back-to-back: four bytes fill the FIFO.
        r0 = rd_cnt;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        push_end();
        for (int k = 0; k < 4; k++) check_frame(bb[k], f[k]);
        for (int k = 0; k < 3; k++)
            check($sformatf("bb_gap_%0d", k), f[k + 1] - f[k], FRAME4 + 3);
        lowcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (!u4_tx) lowcnt++;
        end
        check("bb_no_fifth_frame", lowcnt, 0);
        check("bb_read_count", rd_cnt, r0 + 4);
        check("bb_fifo_empty", empty_r, 1);
        check("bb_no_underflow", underflow_cnt, 0);
        check("bb_no_overflow", overflow_cnt, 0);

        // Second write lands two cycles after the first pop.
        r0 = rd_cnt;
        push(8'h5A);
        push_end();
        for (int i = 0; i < 50 && rd_cnt == r0; i++) @(negedge clk);
        check("lag_first_read", rd_cnt, r0 + 1);
        fork
            begin
                push(8'hC3);
                push_end();
            end
            begin
                check_frame(lag[0], dummy);
                check_frame(lag[1], dummy);
            end
        join
        repeat (10) @(negedge clk);
        check("lag_read_count", rd_cnt, r0 + 2);
        check("lag_no_underflow", underflow_cnt, 0);

        // Reset in the middle of a 0x3C frame, during data bit 0 (a low bit).
        push(8'h3C);
        push_end();
        wait_tx_low(1'b0, ok);
        check("rst_mid_start_seen", ok, 1);
        repeat (5) @(negedge clk);
        check("rst_mid_pre_tx", u4_tx, 0);
        check("rst_mid_pre_busy", u4_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", u4_tx, 1);
        check("rst_mid_busy", u4_busy, 0);
        check("rst_mid_rd_en", u4_rd_en, 0);
        check("rst_mid_byte_done", u4_done, 0);
        @(negedge clk);
        rst = 1'b0;
        r0 = rd_cnt;
        lowcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (!u4_tx) lowcnt++;
        end
        check("post_rst_no_frame", lowcnt, 0);
        check("post_rst_no_read", rd_cnt, r0);

        // Baud scaling: CLKS_PER_BIT=16, byte 0xFF.
        u16_pending = 1'b1;
        wait_tx_low(1'b1, ok);
        check("b16_start_seen", ok, 1);
        if (ok) begin
            start_err = 0;
            body_err  = 0;
            done_pos  = -1;
            done_cnt  = 0;
            for (int j = 0; j < NB * 16 + 16; j++) begin
                if (j > 0) @(negedge clk);
                if (j < 16)       e = 1'b0;
                else if (j < 144) e = 1'b1;
`ifdef UART_TX_PARITY_EN
                else if (j < 160) e = 1'b0;
`endif
                else              e = 1'b1;
                if (u16_tx !== e) begin
                    if (j <= 16) start_err++;
                    else         body_err++;
                end
                if (u16_done === 1'b1) begin
                    done_pos = j;
                    done_cnt++;
                end
            end
            check("b16_start_len", start_err, 0);
            check("b16_data_stop", body_err, 0);
            check("b16_byte_done_pos", done_pos, NB * 16 - 1);
            check("b16_byte_done_cnt", done_cnt, 1);
            check("b16_read_count", rd16_cnt, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
